pent_mem_pager: RTL
===================

PENT_MEM_PAGER -- requirements
Module: pent_mem_pager

Interface
REQ-001 Parameter PAGE_BITS, default 3, sets the RAM page number width; the legal range is 3..5.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchroniser depth for IORQn/WRn; the legal range is 2..3.
REQ-003 CLK  in  1  Single system clock; every register is clocked on its rising edge.
REQ-004 RSTn  in  1  Reset, synchronous and active-low.
REQ-005 D  in  8  CPU data bus.
REQ-006 A15, A14, A1  in  1 each  CPU address bits used for port decode and window select.
REQ-007 IORQn, WRn  in  1 each  CPU I/O request and write strobes, active-low, asynchronous to CLK.
REQ-008 CAS  in  1  DRAM column strobe request, active-high.
REQ-009 DIS  in  1  ROM disable; 1 forces bank 0 to RAM.
REQ-010 LOCK_DIS  in  1  Lock override; only present when PENT_EXT_PAGE_EN is defined.
REQ-011 PAGE  out  PAGE_BITS  RAM page for the current window.
REQ-012 SCR  out  1  Screen select, taken from latched bit D3.
REQ-013 ROMSEL  out  1  ROM half select, taken from latched bit D4.
REQ-014 CAS_RAMn, CAS_ROMn  out  1 each  Gated column strobes, active-low.
REQ-015 LOCKED  out  1  Paging-lock status.

Function
REQ-016 The synchroniser shall pass wr_io = ~(IORQn|WRn) through SYNC_STAGES flops, followed by one edge flop.
- wr_pulse is a one-CLK pulse on a rising edge of the synchronised wr_io.
REQ-017 Port hit: wr_pulse & ~A15 & ~A1, with A15/A1 sampled on the same CLK as the edge.
REQ-018 A port hit with LOCKED=0 shall load the page register on the next rising edge, a latency of 1 CLK after wr_pulse.
- Page register fields: page[2:0]=D[2:0], scr=D3, romsel=D4, lock=D5.
REQ-019 A port hit with LOCKED=1 shall leave all fields unchanged.
REQ-020 Lock is sticky: once set, it is cleared only by reset.
REQ-021 A held write (IORQn/WRn low for many CLKs) shall produce exactly one load.
- A new load requires wr_io to deassert for at least one synchronised sample.
REQ-022 Window mapping is combinational from A15:A14:
- 11 -> PAGE = page register.
- 10 -> PAGE = 2.
- 01 -> PAGE = 5.
- 00 -> PAGE = 0.
- PAGE bits above bit 2 are 0 except in window 11.
REQ-023 rom_area = ~A15 & ~A14 & ~DIS.
- CAS_ROMn = ~(CAS & rom_area).
- CAS_RAMn = ~(CAS & ~rom_area).
- CAS_RAMn and CAS_ROMn are never both low.
REQ-024 SCR, ROMSEL and LOCKED shall be driven directly from the register flops, with no combinational path from D.

Reset
REQ-025 With RSTn=0 at a rising edge, all of the following clear to 0: page register, scr, romsel, lock, synchroniser flops and edge flop.
REQ-026 Reset overrides a simultaneous port hit.
REQ-027 A write strobe that is active while RSTn releases shall not cause a load.
- Because the synchroniser is held at 0, the first wr_pulse after release requires a new falling edge of the strobe.
REQ-028 Outputs after reset: SCR=0, ROMSEL=0, LOCKED=0; window 11 gives PAGE=0.

Configuration
REQ-029 Macro PENT_EXT_PAGE_EN.
REQ-030 Defined:
- D7:D6 load page[4:3], truncated to PAGE_BITS.
- A port hit loads when ~LOCKED | LOCK_DIS, so LOCK_DIS=1 allows writes while locked.
- LOCK_DIS=1 also suppresses setting lock: a write with D5=1 leaves lock unchanged.
REQ-031 Not defined:
- The LOCK_DIS port is absent.
- page bits above bit 2 are tied to 0.
- D7:D6 are ignored.

Verification
REQ-032 Reset, then write 0x07 to port 0x7FFD -> 1+SYNC_STAGES+1 CLKs later, A15:A14=11 gives PAGE=7; A15:A14=01 gives PAGE=5; A15:A14=10 gives PAGE=2.
REQ-033 Write 0x38 (lock) then 0x01 -> LOCKED=1, SCR=1, ROMSEL=1, window-11 PAGE stays 0.
REQ-034 Hold IORQn=WRn=0 for 20 CLKs while D changes 0x01 to 0x02 -> exactly one load, PAGE=1.
REQ-035 CAS=1, A15:A14=00: DIS=0 -> CAS_ROMn=0, CAS_RAMn=1; DIS=1 -> CAS_ROMn=1, CAS_RAMn=0.
REQ-036 PENT_EXT_PAGE_EN with PAGE_BITS=5: lock with 0x20, then set LOCK_DIS=1 and write 0xC3 -> window-11 PAGE=0x1B, LOCKED=1.
REQ-037 Port hit on the same CLK as RSTn=0 -> all outputs 0 afterwards, and no load after RSTn releases.

Source files
------------

// File: rtl/pent_mem_pager.sv
// ---------------------------------------------------------------------------
// pent_mem_pager
//
// Pentagon-style memory pager. CPU writes to port 0x7FFD (A15=0, A1=0) are
// taken from the asynchronous IORQn/WRn strobes through a synchroniser and
// an edge detector, then latched into a page register. That register holds
// the RAM page for the top window, the screen select, the ROM half select
// and a sticky lock bit. The RAM page is remapped per 16K window, and the
// DRAM column strobe is steered to RAM or ROM.
//
// Optional feature macro: PENT_EXT_PAGE_EN
//   When defined, D7:D6 extend the page number (page[4:3], truncated to
//   PAGE_BITS), and the LOCK_DIS port allows writes while locked without
//   allowing the lock to be set.
//
// Parameters
//   PAGE_BITS   RAM page number width, 3..5
//   SYNC_STAGES synchroniser depth for IORQn/WRn, 2..3
//
// Ports
//   CLK        system clock, rising edge
//   RSTn       synchronous active-low reset
//   D          CPU data bus
//   A15,A14,A1 CPU address bits for port decode and window select
//   IORQn,WRn  CPU I/O request / write strobes, active-low, asynchronous
//   CAS        DRAM column strobe request, active-high
//   DIS        ROM disable, 1 maps bank 0 to RAM
//   LOCK_DIS   lock override (PENT_EXT_PAGE_EN only)
//   PAGE       RAM page for the currently addressed window
//   SCR        screen select (latched D3)
//   ROMSEL     ROM half select (latched D4)
//   CAS_RAMn   gated RAM column strobe, active-low
//   CAS_ROMn   gated ROM column strobe, active-low
//   LOCKED     paging lock status
// ---------------------------------------------------------------------------
module pent_mem_pager #(
   parameter int PAGE_BITS   = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic [7:0]           D,
   input  logic                 A15,
   input  logic                 A14,
   input  logic                 A1,
   input  logic                 IORQn,
   input  logic                 WRn,
   input  logic                 CAS,
   input  logic                 DIS,
`ifdef PENT_EXT_PAGE_EN
   input  logic                 LOCK_DIS,
`endif
   output logic [PAGE_BITS-1:0] PAGE,
   output logic                 SCR,
   output logic                 ROMSEL,
   output logic                 CAS_RAMn,
   output logic                 CAS_ROMn,
   output logic                 LOCKED
);

   logic                   wr_io;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   edge_q;
   logic                   armed_q;
   logic                   wr_pulse;
   logic                   port_hit;
   logic                   load_en;
   logic                   lock_set;
   logic [4:0]             page_full;
   logic [PAGE_BITS-1:0]   page_q;
   logic                   scr_q;
   logic                   romsel_q;
   logic                   lock_q;
   logic                   rom_area;

   assign wr_io = ~(IORQn | WRn);

   // fill_q marks when the last synchroniser stage holds a real sample
   // instead of its reset value. armed_q is only set once a genuine
   // "strobe inactive" sample has been seen, so a strobe that was already
   // active across reset release cannot produce a pulse.
   assign wr_pulse = sync_q[SYNC_STAGES-1] & ~edge_q & armed_q;
   assign port_hit = wr_pulse & ~A15 & ~A1;

`ifdef PENT_EXT_PAGE_EN
   assign load_en   = port_hit & (~lock_q | LOCK_DIS);
   assign lock_set  = D[5] & ~LOCK_DIS;
   assign page_full = {D[7:6], D[2:0]};
`else
   logic unused_d;
   assign unused_d  = ^D[7:6];
   assign load_en   = port_hit & ~lock_q;
   assign lock_set  = D[5];
   assign page_full = {2'b00, D[2:0]};
`endif

   // Strobe synchroniser, reset-fill tracker, edge flop and arm flag.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         sync_q  <= '0;
         fill_q  <= '0;
         edge_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], wr_io};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         edge_q <= sync_q[SYNC_STAGES-1];
         if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   // Page register. Lock is sticky and only cleared by reset.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         page_q   <= '0;
         scr_q    <= 1'b0;
         romsel_q <= 1'b0;
         lock_q   <= 1'b0;
      end else if (load_en) begin
         page_q   <= page_full[PAGE_BITS-1:0];
         scr_q    <= D[3];
         romsel_q <= D[4];
         lock_q   <= lock_q | lock_set;
      end
   end

   // Window mapping: only the top window follows the page register.
   always_comb begin
      PAGE = '0;
      unique case ({A15, A14})
         2'b11:   PAGE = page_q;
         2'b10:   PAGE = PAGE_BITS'(3'd2);
         2'b01:   PAGE = PAGE_BITS'(3'd5);
         default: PAGE = '0;
      endcase
   end

   assign rom_area = ~A15 & ~A14 & ~DIS;
   assign CAS_ROMn = ~(CAS & rom_area);
   assign CAS_RAMn = ~(CAS & ~rom_area);

   assign SCR    = scr_q;
   assign ROMSEL = romsel_q;
   assign LOCKED = lock_q;

endmodule
